// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command-line engine.
// The SD_CMD_CRC_CHECK_EN build option is described in sd_cmd_phy.sv.
package sd_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_RESP = 3'd2,
      ST_RECV      = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   localparam logic [1:0] RESP_NONE = 2'b00;
   localparam logic [1:0] RESP_136  = 2'b01;
   localparam logic [1:0] RESP_48   = 2'b10;
   localparam logic [1:0] RESP_48B  = 2'b11;

   localparam int CMD_FRAME_LEN = 48;
   localparam int R2_FRAME_LEN  = 136;

   localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_cmd_phy_if.sv
// Register-file side of the SD command engine: command request fields in,
// captured response and status out.
interface sd_cmd_phy_if;
   logic         new_command;
   logic [5:0]   cmd_index;
   logic [31:0]  argument;
   logic [1:0]   resp_type;
   logic         chk_index;
   logic         chk_crc;
   logic [127:0] response;
   logic         busy;
   logic         cmd_complete;
   logic         cmd_index_error;
   logic         crc_error;
   logic         timeout_error;

   modport master (
      output new_command, cmd_index, argument, resp_type, chk_index, chk_crc,
      input  response, busy, cmd_complete, cmd_index_error, crc_error, timeout_error
   );

   modport slave (
      input  new_command, cmd_index, argument, resp_type, chk_index, chk_crc,
      output response, busy, cmd_complete, cmd_index_error, crc_error, timeout_error
   );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first data, zero initial value.
module sd_crc7
   import sd_cmd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [6:0] crc
);

   logic [6:0] crc_q, crc_d;
   logic       fb;

   always_comb begin
      fb    = bit_in ^ crc_q[6];
      crc_d = crc_q;
      if (clr)
         crc_d = '0;
      else if (en)
         crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   end

   always_ff @(posedge clk) begin
      if (reset) crc_q <= '0;
      else       crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD-line engine: serialises a 48-bit command frame and captures the card response.
// Build option SD_CMD_CRC_CHECK_EN adds the receive CRC7 checker (crc_error tied 0 otherwise).
//
// state      | meaning
// IDLE       | line released, waiting for new_command
// SEND       | driving the 48-bit command frame, then releasing the line
// WAIT_RESP  | sampling cmd_in for the response start bit (Ncr window)
// RECV       | shifting in the rest of the 48- or 136-bit response
// DONE       | one cycle, cmd_complete set and status valid
module sd_cmd_phy
   import sd_cmd_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int TO_W    = 7
) (
   input  logic            clk,
   input  logic            reset,
   sd_cmd_phy_if.slave     rf,
   input  logic            cmd_in,
   output logic            cmd_out,
   output logic            cmd_oe
);

   state_e          state_q, state_d;
   logic [7:0]      bit_cnt_q, bit_cnt_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [39:0]     tx_sh_q, tx_sh_d;
   logic [5:0]      idx_q, idx_d;
   logic [1:0]      resp_q, resp_d;
   logic            chk_index_q, chk_index_d;
   logic [127:0]    rx_sh_q, rx_sh_d;
   logic [127:0]    response_q, response_d;
   logic            cmd_out_q, cmd_out_d;
   logic            cmd_oe_q, cmd_oe_d;
   logic            busy_q, busy_d;
   logic            complete_q, complete_d;
   logic            index_err_q, index_err_d;
   logic            crc_err_q, crc_err_d;
   logic            timeout_err_q, timeout_err_d;

   logic            accept;
   logic [7:0]      cur_idx;
   logic            tx_crc_clr, tx_crc_en;
   logic [6:0]      tx_crc;
   logic            crc_bad;

   assign accept  = (state_q == ST_IDLE) && rf.new_command;
   // bit_cnt holds the number of bits still to go; cur_idx is the frame bit handled this cycle
   assign cur_idx = bit_cnt_q - 8'd1;

   sd_crc7 u_tx_crc (
      .clk    (clk),
      .reset  (reset),
      .clr    (tx_crc_clr),
      .en     (tx_crc_en),
      .bit_in (tx_sh_q[39]),
      .crc    (tx_crc)
   );

`ifdef SD_CMD_CRC_CHECK_EN
   logic       chk_crc_q;
   logic       rx_crc_en;
   logic [6:0] rx_crc;

   always_ff @(posedge clk) begin
      if (reset)       chk_crc_q <= 1'b0;
      else if (accept) chk_crc_q <= rf.chk_crc;
   end

   // Start bit and the R2 header bits 135:128 stay outside the CRC span
   assign rx_crc_en = (state_q == ST_RECV) && (cur_idx >= 8'd8) && (cur_idx <= 8'd127);

   sd_crc7 u_rx_crc (
      .clk    (clk),
      .reset  (reset),
      .clr    (state_q == ST_IDLE),
      .en     (rx_crc_en),
      .bit_in (cmd_in),
      .crc    (rx_crc)
   );

   assign crc_bad = chk_crc_q && (rx_crc != rx_sh_d[7:1]);
`else
   logic unused_chk_crc;
   assign unused_chk_crc = rf.chk_crc;
   assign crc_bad        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (rf.new_command) state_d = ST_SEND;
         ST_SEND:
            if (bit_cnt_q == 8'd0) state_d = (resp_q == RESP_NONE) ? ST_DONE : ST_WAIT_RESP;
         ST_WAIT_RESP:
            if (!cmd_in)                state_d = ST_RECV;
            else if (to_cnt_q == '0)    state_d = ST_DONE;
         ST_RECV:
            if (bit_cnt_q == 8'd1) state_d = ST_DONE;
         ST_DONE:
            state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bit_cnt_d     = bit_cnt_q;
      to_cnt_d      = to_cnt_q;
      tx_sh_d       = tx_sh_q;
      idx_d         = idx_q;
      resp_d        = resp_q;
      chk_index_d   = chk_index_q;
      rx_sh_d       = rx_sh_q;
      response_d    = response_q;
      cmd_out_d     = cmd_out_q;
      cmd_oe_d      = cmd_oe_q;
      busy_d        = busy_q;
      complete_d    = complete_q;
      index_err_d   = index_err_q;
      crc_err_d     = crc_err_q;
      timeout_err_d = timeout_err_q;
      tx_crc_clr    = 1'b0;
      tx_crc_en     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (rf.new_command) begin
               idx_d         = rf.cmd_index;
               resp_d        = rf.resp_type;
               chk_index_d   = rf.chk_index;
               tx_sh_d       = {2'b01, rf.cmd_index, rf.argument};
               bit_cnt_d     = 8'(CMD_FRAME_LEN);
               tx_crc_clr    = 1'b1;
               response_d    = '0;
               busy_d        = 1'b1;
               complete_d    = 1'b0;
               index_err_d   = 1'b0;
               crc_err_d     = 1'b0;
               timeout_err_d = 1'b0;
            end
         end
         ST_SEND: begin
            if (bit_cnt_q != 8'd0) begin
               cmd_oe_d  = 1'b1;
               bit_cnt_d = bit_cnt_q - 8'd1;
               if (cur_idx >= 8'd8) begin
                  cmd_out_d = tx_sh_q[39];
                  tx_sh_d   = {tx_sh_q[38:0], 1'b0};
                  tx_crc_en = 1'b1;
               end else if (cur_idx != 8'd0) begin
                  cmd_out_d = tx_crc[cur_idx[2:0] - 3'd1];
               end else begin
                  cmd_out_d = 1'b1;
               end
            end else begin
               cmd_oe_d  = 1'b0;
               cmd_out_d = 1'b1;
               // down-counter: number of start-bit sample slots left after this one
               to_cnt_d  = TO_W'(TIMEOUT - 1);
               if (resp_q == RESP_NONE) begin
                  busy_d     = 1'b0;
                  complete_d = 1'b1;
               end
            end
         end
         ST_WAIT_RESP: begin
            if (!cmd_in) begin
               bit_cnt_d = (resp_q == RESP_136) ? 8'(R2_FRAME_LEN - 1) : 8'(CMD_FRAME_LEN - 1);
            end else if (to_cnt_q == '0) begin
               timeout_err_d = 1'b1;
               complete_d    = 1'b1;
               busy_d        = 1'b0;
            end else begin
               to_cnt_d = to_cnt_q - 1'b1;
            end
         end
         ST_RECV: begin
            rx_sh_d   = {rx_sh_q[126:0], cmd_in};
            bit_cnt_d = bit_cnt_q - 8'd1;
            if (bit_cnt_q == 8'd1) begin
               busy_d     = 1'b0;
               complete_d = 1'b1;
               crc_err_d  = crc_bad;
               if (resp_q == RESP_136) begin
                  response_d = {8'h00, rx_sh_d[127:8]};
               end else begin
                  response_d  = {96'h0, rx_sh_d[39:8]};
                  index_err_d = chk_index_q && (rx_sh_d[45:40] != idx_q);
               end
            end
         end
         ST_DONE: begin
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt_q     <= '0;
         to_cnt_q      <= '0;
         tx_sh_q       <= '0;
         idx_q         <= '0;
         resp_q        <= RESP_NONE;
         chk_index_q   <= 1'b0;
         rx_sh_q       <= '0;
         response_q    <= '0;
         cmd_out_q     <= 1'b1;
         cmd_oe_q      <= 1'b0;
         busy_q        <= 1'b0;
         complete_q    <= 1'b0;
         index_err_q   <= 1'b0;
         crc_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         bit_cnt_q     <= bit_cnt_d;
         to_cnt_q      <= to_cnt_d;
         tx_sh_q       <= tx_sh_d;
         idx_q         <= idx_d;
         resp_q        <= resp_d;
         chk_index_q   <= chk_index_d;
         rx_sh_q       <= rx_sh_d;
         response_q    <= response_d;
         cmd_out_q     <= cmd_out_d;
         cmd_oe_q      <= cmd_oe_d;
         busy_q        <= busy_d;
         complete_q    <= complete_d;
         index_err_q   <= index_err_d;
         crc_err_q     <= crc_err_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign cmd_out            = cmd_out_q;
   assign cmd_oe             = cmd_oe_q;
   assign rf.response        = response_q;
   assign rf.busy            = busy_q;
   assign rf.cmd_complete    = complete_q;
   assign rf.cmd_index_error = index_err_q;
   assign rf.crc_error       = crc_err_q;
   assign rf.timeout_error   = timeout_err_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Self-checking bench for sd_cmd_phy: directed and randomized commands against a
// polynomial-division CRC model and a bit-serial card model.
module tb_sd_cmd_phy;
   import sd_cmd_pkg::*;

`ifdef SD_CMD_CRC_CHECK_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic cmd_in = 1'b1;
   logic cmd_out, cmd_oe;
   int   n_tests = 0;
   int   n_fail  = 0;

   sd_cmd_phy_if rf ();

   sd_cmd_phy #(.TIMEOUT(64), .TO_W(7)) dut (
      .clk     (clk),
      .reset   (reset),
      .rf      (rf),
      .cmd_in  (cmd_in),
      .cmd_out (cmd_out),
      .cmd_oe  (cmd_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Remainder of data(x) * x^7 divided by x^7 + x^3 + 1; data in the low n bits
   function automatic logic [6:0] crc7_ref(input logic [119:0] data, input int n);
      logic [126:0] v;
      v = {data, 7'b0};
      for (int i = n + 6; i >= 7; i--)
         if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
      return v[6:0];
   endfunction

   // mode: 0 valid response, 1 one payload bit flipped, 2 card silent
   task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic ci, input logic cc, input int mode,
                         input logic [5:0] card_idx, input logic [119:0] payload,
                         input int dly, input bit poke, output logic [47:0] frame_o);
      logic [47:0]  exp_frame, got_frame;
      logic [135:0] rb;
      logic [127:0] exp_resp;
      logic         exp_ierr, exp_cerr, oe_bad;
      int           rlen, p;

      exp_frame = {2'b01, idx, arg, crc7_ref({80'b0, 2'b01, idx, arg}, 40), 1'b1};
      oe_bad    = 1'b0;

      @(negedge clk);
      rf.new_command = 1'b1;
      rf.cmd_index   = idx;
      rf.argument    = arg;
      rf.resp_type   = rt;
      rf.chk_index   = ci;
      rf.chk_crc     = cc;
      @(negedge clk);
      rf.new_command = 1'b0;
      check("busy_after_accept", rf.busy, 1);
      check("status_cleared", {rf.cmd_complete, rf.timeout_error, rf.cmd_index_error, rf.crc_error}, 0);
      check("oe_before_frame", cmd_oe, 0);

      for (int b = 47; b >= 0; b--) begin
         @(negedge clk);
         got_frame[b] = cmd_out;
         if (cmd_oe !== 1'b1) oe_bad = 1'b1;
         rf.new_command = poke && (b == 30);
      end
      rf.new_command = 1'b0;
      frame_o = got_frame;
      check("tx_frame", got_frame, exp_frame);
      check("oe_during_frame", oe_bad, 0);
      check("complete_before_release", rf.cmd_complete, 0);

      @(negedge clk);
      check("line_released", {cmd_oe, cmd_out}, 2'b01);

      if (rt == RESP_NONE) begin
         check("none_complete", {rf.cmd_complete, rf.busy}, 2'b10);
         check("none_errors", {rf.timeout_error, rf.cmd_index_error, rf.crc_error}, 0);
      end else if (mode == 2) begin
         repeat (63) @(negedge clk);
         check("no_timeout_early", {rf.cmd_complete, rf.timeout_error, rf.busy}, 3'b001);
         @(negedge clk);
         check("timeout_flags", {rf.cmd_complete, rf.timeout_error, rf.busy}, 3'b110);
         check("timeout_response", rf.response, 0);
      end else begin
         if (rt == RESP_136) begin
            rlen = 136;
            rb   = {2'b00, 6'h3f, payload, crc7_ref(payload, 120), 1'b1};
         end else begin
            rlen = 48;
            rb   = {88'b0, 2'b00, card_idx, payload[31:0],
                    crc7_ref({80'b0, 2'b00, card_idx, payload[31:0]}, 40), 1'b1};
         end
         if (mode == 1) begin
            p = (rt == RESP_136) ? $urandom_range(127, 8) : $urandom_range(39, 8);
            rb[p] = ~rb[p];
         end
         exp_resp = (rt == RESP_136) ? {8'h00, rb[127:8]} : {96'h0, rb[39:8]};
         exp_ierr = ci && (rt != RESP_136) && (card_idx != idx);
         exp_cerr = CRC_ON && cc && (mode == 1);

         repeat (dly) @(negedge clk);
         for (int j = rlen - 1; j >= 0; j--) begin
            cmd_in = rb[j];
            @(negedge clk);
            if (j == 1) check("complete_before_end_bit", rf.cmd_complete, 0);
         end
         cmd_in = 1'b1;
         check("resp_complete", {rf.cmd_complete, rf.busy, rf.timeout_error}, 3'b100);
         check("response", rf.response, exp_resp);
         check("index_error", rf.cmd_index_error, exp_ierr);
         check("crc_error", rf.crc_error, exp_cerr);
      end

      if (poke) begin
         rf.new_command = 1'b1;
         @(negedge clk);
         rf.new_command = 1'b0;
         check("done_cmd_ignored", {rf.busy, rf.cmd_complete}, 2'b01);
         @(negedge clk);
         check("done_cmd_still_idle", {rf.busy, cmd_oe}, 2'b00);
      end
   endtask

   initial begin
      logic [47:0]  fr;
      logic [5:0]   ridx, cidx;
      logic [1:0]   rrt;
      logic [119:0] pay;
      int           md;

      rf.new_command = 1'b0;
      rf.cmd_index   = '0;
      rf.argument    = '0;
      rf.resp_type   = RESP_NONE;
      rf.chk_index   = 1'b0;
      rf.chk_crc     = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_line", {cmd_oe, cmd_out}, 2'b01);
      check("reset_status", {rf.busy, rf.cmd_complete, rf.cmd_index_error, rf.crc_error, rf.timeout_error}, 0);
      check("reset_response", rf.response, 0);
      reset = 1'b0;

      // CMD0, no response
      do_cmd(6'd0, 32'h0, RESP_NONE, 1'b0, 1'b0, 0, 6'd0, 120'h0, 0, 1'b1, fr);
      check("cmd0_frame_const", fr, 48'h400000000095);

      // CMD17 with valid R1
      do_cmd(6'd17, 32'h0, RESP_48, 1'b1, 1'b1, 0, 6'd17, 120'h900, 3, 1'b0, fr);

      // CMD8 answered with the wrong index
      do_cmd(6'd8, 32'h000001AA, RESP_48, 1'b1, 1'b0, 0, 6'd9, 120'h1AA, 2, 1'b0, fr);
      check("cmd8_frame_const", fr, 48'h48000001AA87);

      // timeout with cmd_in held high
      do_cmd(6'd2, 32'hDEADBEEF, RESP_48, 1'b0, 1'b0, 2, 6'd0, 120'h0, 0, 1'b1, fr);

      // R1 with a corrupted payload bit
      do_cmd(6'd17, 32'h0, RESP_48, 1'b1, 1'b1, 1, 6'd17, 120'h900, 1, 1'b0, fr);

      // R2 valid, then R2 corrupted; 48-bit-with-busy treated as 48
      do_cmd(6'd2, 32'h0, RESP_136, 1'b1, 1'b1, 0, 6'd0,
             {$urandom, $urandom, $urandom, 24'hA5C3E1}, 5, 1'b0, fr);
      do_cmd(6'd9, 32'h1234_0000, RESP_136, 1'b0, 1'b1, 1, 6'd0,
             {$urandom, $urandom, $urandom, 24'h0F0F0F}, 0, 1'b0, fr);
      do_cmd(6'd7, 32'h0001_0000, RESP_48B, 1'b1, 1'b1, 0, 6'd7, 120'hCAFE_F00D, 4, 1'b0, fr);

      // reset while bit 20 of the frame is on the line
      @(negedge clk);
      rf.new_command = 1'b1;
      rf.cmd_index   = 6'd17;
      rf.argument    = 32'h1234_5678;
      rf.resp_type   = RESP_48;
      @(negedge clk);
      rf.new_command = 1'b0;
      repeat (28) @(negedge clk);
      check("pre_reset_oe", cmd_oe, 1);
      reset = 1'b1;
      @(negedge clk);
      check("midframe_reset_line", {cmd_oe, cmd_out}, 2'b01);
      check("midframe_reset_busy", {rf.busy, rf.cmd_complete}, 2'b00);
      reset = 1'b0;
      do_cmd(6'd0, 32'h0, RESP_NONE, 1'b0, 1'b0, 0, 6'd0, 120'h0, 0, 1'b0, fr);
      check("cmd0_after_reset", fr, 48'h400000000095);

      // randomized commands
      for (int t = 0; t < 14; t++) begin
         ridx = 6'($urandom_range(63, 0));
         rrt  = 2'($urandom_range(3, 0));
         md   = $urandom_range(3, 0);
         if (md == 3) md = 0;
         cidx = ($urandom_range(2, 0) == 0) ? (ridx ^ 6'(1 << $urandom_range(5, 0))) : ridx;
         pay  = {$urandom, $urandom, $urandom, 24'($urandom)};
         do_cmd(ridx, $urandom, rrt, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                md, cidx, pay, $urandom_range(20, 0), 1'($urandom_range(1, 0)), fr);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
